// File: rtl/exp_prec_pipe.sv
// rtl/exp_prec_pipe.sv - two-stage valid/ready restorer from narrow to wide signed fixed-point
module exp_prec_pipe #(
    parameter int I_PREC = 8,
    parameter int I_FRAC = 4,
    parameter int O_PREC = 16,
    parameter int O_FRAC = 8,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              reset_,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [I_PREC-1:0] in_data,
    input  logic              in_udf,
    input  logic              in_ovf,
    input  logic              in_rnd,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [O_PREC-1:0] out_data,
    output logic              out_lossy,
    input  logic              cnt_clr,
    output logic [CNT_W-1:0]  smp_cnt,
    output logic [CNT_W-1:0]  udf_cnt,
    output logic [CNT_W-1:0]  ovf_cnt,
    output logic [CNT_W-1:0]  rnd_cnt
);

    // Widening only moves the binary point left by this many bits.
    localparam int SHIFT = O_FRAC - I_FRAC;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic              v1;
    logic              v2;
    logic [I_PREC-1:0] s1_data;
    logic              s1_lossy;
    logic              ld1;
    logic              ld2;
    logic              accept;
    logic [O_PREC-1:0] wide;

    // A stage may load when it is empty or the stage after it is moving.
    always_comb begin
        ld2      = ~v2 | out_ready;
        ld1      = ~v1 | ld2;
        in_ready = ld1;
        accept   = in_valid & ld1;
        wide     = {{(O_PREC-I_PREC){s1_data[I_PREC-1]}}, s1_data} << SHIFT;
    end

    assign out_valid = v2;

    // Stage 1 captures the narrow sample and collapses its loss flags.
    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) begin
            v1       <= 1'b0;
            s1_data  <= '0;
            s1_lossy <= 1'b0;
        end else if (ld1) begin
            v1 <= accept;
            if (accept) begin
                s1_data  <= in_data;
                s1_lossy <= in_udf | in_ovf | in_rnd;
            end
        end
    end

    // Stage 2 holds the exact wide value; it is frozen while stalled.
    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) begin
            v2        <= 1'b0;
            out_data  <= '0;
            out_lossy <= 1'b0;
        end else if (ld2) begin
            v2 <= v1;
            if (v1) begin
                out_data  <= wide;
                out_lossy <= s1_lossy;
            end
        end
    end

    function automatic logic [CNT_W-1:0] bump(input logic [CNT_W-1:0] c, input logic en);
        return (en && (c != CNT_MAX)) ? c + CNT_W'(1) : c;
    endfunction

    // Saturating status counters; a clear wins over a coincident accept.
    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) begin
            smp_cnt <= '0;
            udf_cnt <= '0;
            ovf_cnt <= '0;
            rnd_cnt <= '0;
        end else if (cnt_clr) begin
            smp_cnt <= '0;
            udf_cnt <= '0;
            ovf_cnt <= '0;
            rnd_cnt <= '0;
        end else begin
            smp_cnt <= bump(smp_cnt, accept);
            udf_cnt <= bump(udf_cnt, accept & in_udf);
            ovf_cnt <= bump(ovf_cnt, accept & in_ovf);
            rnd_cnt <= bump(rnd_cnt, accept & in_rnd);
        end
    end

endmodule
